// File: rtl/conv_ofm_collector_if.sv
// Beat stream from the conv kernel into the collector, plus the OFM buffer write port.
// vld_i has no ready: a beat is transferred on every rising edge where vld_i=1, and ofm_we is a single-cycle write strobe.
interface conv_ofm_collector_if #(
    parameter int ACC_W = 20,
    parameter int AW    = 16
);
    logic                 vld_i;
    logic [4*ACC_W-1:0]   acc_i;
    logic                 ofm_we;
    logic [AW-1:0]        ofm_addr;
    logic [31:0]          ofm_wdata;

    modport mst (output vld_i, acc_i, input ofm_we, ofm_addr, ofm_wdata);
    modport slv (input vld_i, acc_i, output ofm_we, ofm_addr, ofm_wdata);
endinterface

// File: rtl/conv_ofm_collector.sv
// Collects four-channel accumulator beats, descales/ReLUs/saturates them to int8 and
// writes packed words to the OFM buffer in raster order, tracking row/col and frame end.
module conv_ofm_collector #(
    parameter int IFM_WIDTH  = 16,
    parameter int IFM_HEIGHT = 16,
    parameter int ACC_W      = 20,
    parameter int SHIFT      = 12,
    parameter int AW         = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  relu_en,
    input  logic [AW-1:0]         ofm_base,
    conv_ofm_collector_if.slv     bus,
    output logic [15:0]           row_o,
    output logic [15:0]           col_o,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  ovf_err,
    output logic [15:0]           sat_cnt,
    output logic [1:0]            state_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

    state_t        state_q;
    logic [15:0]   row_q, col_q;
    logic [AW-1:0] pix_q, base_q;
    logic          relu_q, ovf_q, busy_q, done_q;

    logic          s1_vld_q, s1_last_q;
    logic [31:0]   s1_lane_q;
    logic [3:0]    s1_flag_q;
    logic [AW-1:0] s1_addr_q;

    logic          ofm_we_q, we_last_q;
    logic [31:0]   ofm_wdata_q;
    logic [AW-1:0] ofm_addr_q;
    logic [15:0]   sat_q;

    logic [7:0]    lane_d [4];
    logic [3:0]    flag_d;
    logic [2:0]    flag_cnt_d;
    logic [16:0]   sat_sum_d;
    logic [15:0]   sat_d;
    logic          accept_d, last_px_d, s2_fire_d;

    // A lane that lands on either int8 rail counts as clipped; a ReLU clamp to 0 does not.
    function automatic logic [8:0] lane_fn(input logic [ACC_W-1:0] acc, input logic relu);
        logic signed [ACC_W-1:0] t;
        t = $signed(acc) >>> SHIFT;
        if (relu && t[ACC_W-1]) t = '0;
        if (t >= SAT_HI) return {1'b1, 8'h7F};
        if (t <= SAT_LO) return {1'b1, 8'h80};
        return {1'b0, t[7:0]};
    endfunction

    always_comb begin
        flag_d = '0;
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = '0;
            {flag_d[i], lane_d[i]} = lane_fn(bus.acc_i[i*ACC_W +: ACC_W], relu_q);
        end
        flag_cnt_d = 3'(s1_flag_q[0]) + 3'(s1_flag_q[1]) + 3'(s1_flag_q[2]) + 3'(s1_flag_q[3]);
        sat_sum_d  = 17'(sat_q) + 17'(flag_cnt_d);
        sat_d      = sat_sum_d[16] ? 16'hFFFF : sat_sum_d[15:0];
        accept_d   = bus.vld_i && !start && (state_q == S_RUN);
        last_px_d  = (row_q == 16'(IFM_HEIGHT - 1)) && (col_q == 16'(IFM_WIDTH - 1));
        // start kills whatever sits in stage 1 so an aborted frame never writes again.
        s2_fire_d  = s1_vld_q && !start;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_lane_q   <= '0;
            s1_flag_q   <= '0;
            s1_addr_q   <= '0;
            ofm_we_q    <= 1'b0;
            we_last_q   <= 1'b0;
            ofm_wdata_q <= '0;
            ofm_addr_q  <= '0;
            sat_q       <= '0;
        end else begin
            s1_vld_q  <= accept_d;
            ofm_we_q  <= s2_fire_d;
            we_last_q <= s2_fire_d && s1_last_q;
            if (accept_d) begin
                s1_lane_q <= {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
                s1_flag_q <= flag_d;
                s1_addr_q <= base_q + pix_q;
                s1_last_q <= last_px_d;
            end
            if (s2_fire_d) begin
                ofm_wdata_q <= s1_lane_q;
                ofm_addr_q  <= s1_addr_q;
            end
            if (start)         sat_q <= '0;
            else if (s1_vld_q) sat_q <= sat_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            base_q  <= '0;
            relu_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q <= S_RUN;
                row_q   <= '0;
                col_q   <= '0;
                pix_q   <= '0;
                base_q  <= ofm_base;
                relu_q  <= relu_en;
                ovf_q   <= 1'b0;
                busy_q  <= 1'b1;
            end else begin
                if (bus.vld_i && state_q != S_RUN) ovf_q <= 1'b1;
                case (state_q)
                    S_RUN: if (bus.vld_i) begin
                        pix_q <= pix_q + AW'(1);
                        if (col_q == 16'(IFM_WIDTH - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + 16'd1;
                        end else begin
                            col_q <= col_q + 16'd1;
                        end
                        if (last_px_d) state_q <= S_DRAIN;
                    end
                    // busy stays up through the drain and drops together with frame_done.
                    S_DRAIN: if (we_last_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.ofm_we    = ofm_we_q;
    assign bus.ofm_addr  = ofm_addr_q;
    assign bus.ofm_wdata = ofm_wdata_q;
    assign row_o         = row_q;
    assign col_o         = col_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign ovf_err       = ovf_q;
    assign sat_cnt       = sat_q;
    assign state_o       = state_q;
endmodule
